hamming_secded_counter: RTL

Parametrised successor to the team's 16-bit Hamming-coded counter. It holds the count as a SEC-DED codeword, decodes and scrubs that codeword every cycle, and supports up/down counting, synchronous load and error injection. It sits wherever a radiation-tolerant event or timebase counter is needed. With the default DATA_W=11, its 16-bit codeword output is a drop-in for the existing counter bus.

---
 rtl/hamming_pkg.sv | 70 +++++++
 rtl/hamming_secded_dec.sv | 42 ++++
 rtl/hamming_secded_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared SEC-DED helpers: parity-bit count, codeword encode/extract, decode result type.
// Codeword: bit 0 = overall even parity, bits 1.. = Hamming positions (parity at powers of two).
package hamming_pkg;

  localparam int MAX_DATA_W = 57;
  localparam int MAX_CW_W   = 64;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  sec;
    logic                  ded;
  } dec_t;

  // Smallest P with 2^P >= data_w + P + 1; the descending scan leaves the smallest match.
  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic logic is_pow2(input int i);
    return (i != 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic logic [MAX_CW_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                 input int cw_w);
    logic [MAX_CW_W-1:0] cw;
    logic [5:0]          syn;
    logic [5:0]          j;
    logic [5:0]          pos;
    cw  = '0;
    syn = '0;
    j   = '0;
    for (int k = 1; k < MAX_CW_W; k++) begin
      if (k < cw_w && !is_pow2(k)) begin
        cw[k[5:0]] = data[j];
        j = j + 6'd1;
      end
    end
    for (int k = 1; k < MAX_CW_W; k++) begin
      if (cw[k[5:0]]) syn = syn ^ k[5:0];
    end
    // Writing the data-only syndrome into the parity slots cancels it to zero.
    for (int b = 0; b < 6; b++) begin
      pos = 6'd1 << b;
      if ((1 << b) < cw_w) cw[pos] = syn[b[2:0]];
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] extract(input logic [MAX_CW_W-1:0] cw,
                                                    input int cw_w);
    logic [MAX_DATA_W-1:0] data;
    logic [5:0]            j;
    data = '0;
    j    = '0;
    for (int k = 1; k < MAX_CW_W; k++) begin
      if (k < cw_w && !is_pow2(k)) begin
        data[j] = cw[k[5:0]];
        j = j + 6'd1;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder/corrector; zero latency, no flow control.
// Under DED the data field is the raw, uncorrected extraction.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 11,
  localparam int P      = calc_p(DATA_W),
  localparam int CW_W   = DATA_W + P + 1
) (
  input  logic [CW_W-1:0] cw,
  output dec_t            res
);

  logic [MAX_CW_W-1:0] cw_x;
  logic [MAX_CW_W-1:0] fixed;
  logic [5:0]          syn;
  logic                par;

  always_comb begin
    cw_x  = MAX_CW_W'(cw);
    fixed = cw_x;
    syn   = '0;
    par   = ^cw;
    res   = '0;
    for (int k = 1; k < MAX_CW_W; k++) begin
      if (cw_x[k[5:0]]) syn = syn ^ k[5:0];
    end
    // Odd parity with an in-range syndrome is one flipped bit; syn=0 is the parity bit itself.
    if (par) begin
      if (int'(syn) < CW_W) begin
        res.sec    = 1'b1;
        fixed[syn] = ~fixed[syn];
      end else begin
        res.ded = 1'b1;
      end
    end else if (syn != '0) begin
      res.ded = 1'b1;
    end
    res.data = extract(res.ded ? cw_x : fixed, CW_W);
  end

endmodule

// File: rtl/hamming_secded_counter.sv
// SEC-DED protected up/down counter, scrubbed every cycle; load/count/inject land after one edge.
// No backpressure: every input is sampled each cycle, error flags are combinational from the register.
module hamming_secded_counter
  import hamming_pkg::*;
#(
  parameter  int DATA_W   = 11,
  parameter  int ERRCNT_W = 8,
  localparam int P        = calc_p(DATA_W),
  localparam int CW_W     = DATA_W + P + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_val,
  input  logic                inj_en,
  input  logic [CW_W-1:0]     inj_mask,
  input  logic                clr_err,
  output logic [CW_W-1:0]     counter,
  output logic [DATA_W-1:0]   count,
  output logic                sec_err,
  output logic                ded_err,
  output logic                ded_sticky,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic [CW_W-1:0]   cw_q;
  logic [CW_W-1:0]   cw_d;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] nxt;
  dec_t              dec;

  hamming_secded_dec #(.DATA_W(DATA_W)) u_dec (
    .cw  (cw_q),
    .res (dec)
  );

  assign cur = dec.data[DATA_W-1:0];

  generate
    if (DATA_W < MAX_DATA_W) begin : g_hi
      logic unused_dec_hi;
      assign unused_dec_hi = ^dec.data[MAX_DATA_W-1:DATA_W];
    end
  endgenerate

  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = load_val;
    end else if (enable) begin
      nxt = up ? cur + 1'b1 : cur - 1'b1;
    end
    // An uncorrectable word is frozen for diagnosis until software reloads it.
    if (dec.ded && !load) begin
      cw_d = cw_q;
    end else begin
      cw_d = CW_W'(encode(MAX_DATA_W'(nxt), CW_W));
    end
    if (inj_en) cw_d = cw_d ^ inj_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_q       <= '0;
      ded_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      cw_q <= cw_d;
      if (dec.ded) begin
        ded_sticky <= 1'b1;
      end else if (clr_err) begin
        ded_sticky <= 1'b0;
      end
      if (clr_err) begin
        err_cnt <= ERRCNT_W'(dec.sec);
      end else if (dec.sec && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign counter = cw_q;
  assign count   = cur;
  assign sec_err = dec.sec;
  assign ded_err = dec.ded;

endmodule
